// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and constants for the PC / fetch-redirect stage.
// FSM encoding, target-adder request/response structs, sequential-PC helper.
package pc_redirect_unit_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam int FCNT_W      = 3;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic            is_jalr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
  } tgt_req_t;

  typedef struct packed {
    logic [XLEN-1:0] target;
    logic            misaligned;
  } tgt_rsp_t;

  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] cur);
    return cur + XLEN'(INSTR_BYTES);
  endfunction
endpackage

// File: rtl/pc_redirect_unit_if.sv
// EX-side redirect inputs plus instruction-memory request handshake.
// slave = the redirect unit, master = the core / memory side driving it.
interface pc_redirect_unit_if;
  import pc_redirect_unit_pkg::*;
  logic            ex_valid;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic            branch_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1;
  logic            stall;
  logic            imem_ready;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            misalign_trap;
  logic [XLEN-1:0] trap_tval;

  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, branch_taken,
           ex_pc, ex_imm, ex_rs1, stall, imem_ready,
    output imem_req_valid, imem_addr, pc, flush, misalign_trap, trap_tval
  );

  modport master (
    output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, branch_taken,
           ex_pc, ex_imm, ex_rs1, stall, imem_ready,
    input  imem_req_valid, imem_addr, pc, flush, misalign_trap, trap_tval
  );
endinterface

// File: rtl/pc_redirect_unit_next_pc_calc.sv
// Combinational redirect target: base + imm, JALR LSB clear, word-alignment check.
module next_pc_calc
  import pc_redirect_unit_pkg::*;
(
  input  tgt_req_t req,
  output tgt_rsp_t rsp
);
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  assign base = req.is_jalr ? req.rs1 : req.pc;
  assign sum  = base + req.imm;

  always_comb begin
    rsp            = '0;
    rsp.target     = req.is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    // bit 0 of a branch/JAL target is zero by encoding; only bit 1 can fault
    rsp.misaligned = rsp.target[1];
  end
endmodule

// File: rtl/pc_redirect_unit.sv
// PC register, boot FSM, redirect/trap handling and wrong-path flush counter.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              FLUSH_CYCLES = 2
)(
  input logic            clk,
  input logic            rst,
  pc_redirect_unit_if.slave bus
);
  logic [XLEN-1:0]   pc_q;
  logic [0:0]        state_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              trap_q;
  logic [XLEN-1:0]   tval_q;

  logic     req_valid;
  logic     flush;
  logic     take;
  logic     redirect;
  tgt_req_t treq;
  tgt_rsp_t trsp;

  assign req_valid = (state_q == ST_RUN);
  assign flush     = (fcnt_q != '0);
  assign take      = (bus.ex_is_branch & bus.branch_taken) | bus.ex_is_jal | bus.ex_is_jalr;
  // anything EX presents while flushing is itself wrong-path
  assign redirect  = bus.ex_valid & ~flush & take;

  always_comb begin
    treq         = '0;
    treq.is_jalr = bus.ex_is_jalr;
    treq.pc      = bus.ex_pc;
    treq.imm     = bus.ex_imm;
    treq.rs1     = bus.ex_rs1;
  end

  next_pc_calc u_calc (
    .req (treq),
    .rsp (trsp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      state_q <= ST_BOOT;
      fcnt_q  <= '0;
      trap_q  <= 1'b0;
      tval_q  <= '0;
    end else begin
      state_q <= ST_RUN;
      trap_q  <= 1'b0;
      fcnt_q  <= flush ? fcnt_q - 1'b1 : fcnt_q;
      if (redirect) begin
        fcnt_q <= FCNT_W'(FLUSH_CYCLES);
        if (trsp.misaligned) begin
          pc_q   <= TRAP_VECTOR;
          trap_q <= 1'b1;
          tval_q <= trsp.target;
        end else begin
          pc_q <= trsp.target;
        end
      end else if (!bus.stall && req_valid && bus.imem_ready) begin
        pc_q <= seq_pc(pc_q);
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.pc             = pc_q;
  assign bus.flush          = flush;
  assign bus.misalign_trap  = trap_q;
  assign bus.trap_tval      = tval_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: directed scenarios then random traffic,
// expected per-cycle outputs queued by a behavioural model and checked by a monitor.
module tb_pc_redirect_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pc_redirect_unit_if bus ();

  pc_redirect_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          known;
    logic [31:0] pc;
    logic        req_valid;
    logic        flush;
    logic        trap;
    logic [31:0] tval;
  } exp_t;

  exp_t exp_q[$];

  // behavioural model state for the current cycle
  bit          m_known = 0;
  bit          m_boot;
  logic [31:0] m_pc;
  int          m_flush_left;
  logic        m_trap;
  logic [31:0] m_tval;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.known) begin
        cmp("pc",        bus.pc,                     e.pc);
        cmp("imem_addr", bus.imem_addr,              e.pc);
        cmp("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, e.req_valid});
        cmp("flush",     {31'b0, bus.flush},          {31'b0, e.flush});
        cmp("trap",      {31'b0, bus.misalign_trap},  {31'b0, e.trap});
        cmp("tval",      bus.trap_tval,               e.tval);
      end
    end
  end

  // kind: 0 none, 1 taken branch, 2 not-taken branch, 3 JAL, 4 JALR
  task automatic step(input bit r, input bit v, input int kind, input logic [31:0] epc,
                      input logic [31:0] imm, input logic [31:0] rs1, input bit st, input bit rdy);
    exp_t        e;
    bit          redir;
    logic [31:0] tgt;
    rst              = r;
    bus.ex_valid     = v;
    bus.ex_is_branch = (kind == 1 || kind == 2);
    bus.branch_taken = (kind == 1);
    bus.ex_is_jal    = (kind == 3);
    bus.ex_is_jalr   = (kind == 4);
    bus.ex_pc        = epc;
    bus.ex_imm       = imm;
    bus.ex_rs1       = rs1;
    bus.stall        = st;
    bus.imem_ready   = rdy;
    e.known     = m_known;
    e.pc        = m_pc;
    e.req_valid = !m_boot;
    e.flush     = (m_flush_left > 0);
    e.trap      = m_trap;
    e.tval      = m_tval;
    exp_q.push_back(e);
    redir = v && (m_flush_left == 0) && (kind == 1 || kind == 3 || kind == 4);
    tgt   = (kind == 4) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (epc + imm);
    if (r) begin
      m_known = 1; m_boot = 1; m_pc = 32'h0; m_flush_left = 0; m_trap = 0; m_tval = 32'h0;
    end else begin
      m_trap = 0;
      if (m_flush_left > 0) m_flush_left--;
      if (redir) begin
        m_flush_left = 2;
        if ((tgt % 4) >= 2) begin
          m_pc = 32'h100; m_trap = 1; m_tval = tgt;
        end else m_pc = tgt;
      end else if (!st && !m_boot && rdy) m_pc = m_pc + 4;
      m_boot = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, rdy);
  endtask

  initial begin
    int kind;
    logic [31:0] imm;
    rst = 1'b1;
    bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_is_jal = 0; bus.ex_is_jalr = 0;
    bus.branch_taken = 0; bus.ex_pc = '0; bus.ex_imm = '0; bus.ex_rs1 = '0;
    bus.stall = 0; bus.imem_ready = 1;
    @(posedge clk); #1;

    step(1, 0, 0, 0, 0, 0, 0, 1);
    cmp("rst_pc", bus.pc, 32'h0);
    cmp("rst_req", {31'b0, bus.imem_req_valid}, 32'h0);
    idle(1); cmp("boot_addr0", bus.imem_addr, 32'h0);
    cmp("boot_req", {31'b0, bus.imem_req_valid}, 32'h1);
    idle(1); cmp("seq_addr4", bus.imem_addr, 32'h4);
    idle(1); cmp("seq_addr8", bus.imem_addr, 32'h8);
    repeat (3) idle(0);
    cmp("hold_addr8", bus.imem_addr, 32'h8);
    idle(1); cmp("ready_addrC", bus.imem_addr, 32'hC);

    step(0, 1, 1, 32'h10, 32'h20, 0, 0, 1);
    cmp("beq_addr", bus.imem_addr, 32'h30);
    cmp("beq_flush1", {31'b0, bus.flush}, 32'h1);
    step(0, 1, 3, 32'h0, 32'h80, 0, 0, 1);
    cmp("ignored_jal", bus.imem_addr, 32'h34);
    cmp("beq_flush2", {31'b0, bus.flush}, 32'h1);
    idle(1); cmp("beq_flush_end", {31'b0, bus.flush}, 32'h0);

    step(0, 1, 4, 0, 32'h2, 32'h101, 0, 0);
    cmp("jalr_trap", {31'b0, bus.misalign_trap}, 32'h1);
    cmp("jalr_tval", bus.trap_tval, 32'h102);
    cmp("jalr_pc", bus.pc, 32'h100);
    idle(0); cmp("trap_pulse", {31'b0, bus.misalign_trap}, 32'h0);
    cmp("tval_held", bus.trap_tval, 32'h102);
    idle(0);
    step(0, 1, 4, 0, 32'h0, 32'h103, 0, 0);
    cmp("jalr_lsb_trap", {31'b0, bus.misalign_trap}, 32'h1);
    cmp("jalr_lsb_tval", bus.trap_tval, 32'h102);
    idle(0); idle(0);
    step(0, 1, 4, 0, 32'h0, 32'h201, 0, 0);
    cmp("jalr_ok_pc", bus.pc, 32'h200);
    cmp("jalr_ok_trap", {31'b0, bus.misalign_trap}, 32'h0);
    idle(0); idle(0);
    step(0, 1, 2, 32'h20, 32'h20, 0, 0, 1);
    cmp("not_taken", bus.pc, 32'h204);
    step(0, 1, 1, 32'h20, 32'h20, 0, 1, 1);
    cmp("stall_redirect", bus.pc, 32'h40);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    cmp("rst_flush_pc", bus.pc, 32'h0);
    cmp("rst_flush", {31'b0, bus.flush}, 32'h0);

    repeat (3000) begin
      kind = $urandom_range(0, 4);
      imm  = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 1) << 1);
      if ($urandom_range(0, 7) == 0) imm = imm | 32'hFFFF_F000;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, kind,
           {$urandom_range(0, 4095), 2'b00}, imm, $urandom(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7);
    end
    idle(1);
    repeat (4) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    cmp("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
